// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the divider and multiplier datapaths.
package fp16_pkg;

  localparam int FP_EXP_BIAS = 15;
  localparam int FP_EXP_W    = 5;
  localparam int FP_FRAC_W   = 10;
  localparam logic [14:0] FP_SAT_MAG = 15'h7FFF;

  typedef enum logic [1:0] {IDLE, DIV, RND, DONE} div_state_t;

  typedef struct packed {
    logic                 hidden;
    logic [FP_FRAC_W-1:0] frac;
    logic [FP_EXP_W-1:0]  eff_exp;
  } fp_unpacked_t;

  // Subnormals take exponent 1 so their weight lines up with the smallest normal.
  function automatic fp_unpacked_t fp_unpack(input logic [15:0] x);
    fp_unpacked_t u;
    u.hidden  = (x[14:10] != '0);
    u.frac    = x[9:0];
    u.eff_exp = u.hidden ? x[14:10] : 5'd1;
    return u;
  endfunction

endpackage

// File: rtl/fp16_lzc11.sv
// Leading-zero count of an 11-bit mantissa; returns 11 for an all-zero input.
module fp16_lzc11 (
  input  logic [10:0] m,
  output logic [3:0]  lz
);

  always_comb begin
    lz = 4'd11;
    for (int i = 0; i < 11; i++) begin
      if (m[i]) lz = 4'(10 - i);
    end
  end

endmodule

// File: rtl/fp16_div_iter.sv
// Iterative FP16 divider: radix-2 restoring quotient, one bit per cycle, RNE rounding.
//  state | meaning
//  IDLE  | waiting for operands, in_ready=1
//  DIV   | producing one quotient bit per cycle
//  RND   | normalise, denormalise, round, resolve specials
//  DONE  | result held until out_ready
module fp16_div_iter
  import fp16_pkg::*;
#(
  parameter int Q_BITS = 14
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out,
  output logic        overflow,
  output logic        sub,
  output logic        dz
);

  localparam int CNT_W = $clog2(Q_BITS);
  localparam int X_W   = Q_BITS + 1;

  div_state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic              sign_r, a_zero, b_zero;
  logic [10:0]       mb_r;
  logic [11:0]       rem;
  logic [Q_BITS-1:0] q;
  logic signed [6:0] exp_r;

  fp_unpacked_t ua, ub;
  logic [10:0]  ma_raw, mb_raw, ma_norm, mb_norm;
  logic [3:0]   lza, lzb;
  logic [6:0]   exp_acc;

  assign ua      = fp_unpack(a);
  assign ub      = fp_unpack(b);
  assign ma_raw  = {ua.hidden, ua.frac};
  assign mb_raw  = {ub.hidden, ub.frac};
  assign ma_norm = ma_raw << lza;
  assign mb_norm = mb_raw << lzb;
  assign exp_acc = {2'b0, ua.eff_exp} - {2'b0, ub.eff_exp} + 7'(FP_EXP_BIAS)
                 - {3'b0, lza} + {3'b0, lzb};

  fp16_lzc11 u_lzc_a (.m(ma_raw), .lz(lza));
  fp16_lzc11 u_lzc_b (.m(mb_raw), .lz(lzb));

  // Compare before doubling so the first bit is the integer bit of ma/mb.
  logic        rem_ge;
  logic [11:0] rem_sub;
  assign rem_ge  = (rem >= {1'b0, mb_r});
  assign rem_sub = rem_ge ? (rem - {1'b0, mb_r}) : rem;

  logic [Q_BITS-1:0] q_n;
  logic signed [6:0] e_n;
  logic [X_W-1:0]    x, shifted;
  logic [6:0]        shamt;
  logic              lost, guard, rs, inc, sat;
  logic [4:0]        exp_base;
  logic [14:0]       res15;

  always_comb begin
    q_n   = q[Q_BITS-1] ? q : {q[Q_BITS-2:0], 1'b0};
    e_n   = q[Q_BITS-1] ? exp_r : (exp_r - 7'sd1);
    x     = {q_n, |rem};
    shamt = (e_n > 7'sd0) ? 7'd0 : 7'(7'sd1 - e_n);
    shifted = x >> shamt;
    lost  = (x != (shifted << shamt));
    guard = shifted[Q_BITS-11];
    rs    = (|shifted[Q_BITS-12:0]) | lost;
    inc   = guard & (rs | shifted[Q_BITS-10]);
    // Hidden bit still in place means a normal result; otherwise exponent field is 0.
    exp_base = shifted[Q_BITS] ? e_n[4:0] : 5'd0;
    res15 = {exp_base, shifted[Q_BITS-1 -: 10]} + 15'(inc);
    sat   = (e_n > 7'sd30) || (res15[14:10] == 5'h1F);
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)     state_nxt = DIV;
      DIV:  if (cnt == '0)    state_nxt = RND;
      RND:                    state_nxt = DONE;
      DONE: if (out_ready)    state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      out      <= '0;
      overflow <= 1'b0;
      sub      <= 1'b0;
      dz       <= 1'b0;
      cnt      <= '0;
      sign_r   <= 1'b0;
      a_zero   <= 1'b0;
      b_zero   <= 1'b0;
      mb_r     <= '0;
      rem      <= '0;
      q        <= '0;
      exp_r    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_r <= a[15] ^ b[15];
          a_zero <= (ma_raw == '0);
          b_zero <= (mb_raw == '0);
          mb_r   <= mb_norm;
          rem    <= {1'b0, ma_norm};
          exp_r  <= exp_acc;
          cnt    <= CNT_W'(Q_BITS - 1);
        end
        DIV: begin
          rem <= rem_sub << 1;
          q   <= {q[Q_BITS-2:0], rem_ge};
          cnt <= cnt - 1'b1;
        end
        RND: begin
          if (b_zero) begin
            out <= {sign_r, FP_SAT_MAG}; overflow <= 1'b1; sub <= 1'b0; dz <= 1'b1;
          end else if (a_zero) begin
            out <= {sign_r, 15'h0};      overflow <= 1'b0; sub <= 1'b1; dz <= 1'b0;
          end else if (sat) begin
            out <= {sign_r, FP_SAT_MAG}; overflow <= 1'b1; sub <= 1'b0; dz <= 1'b0;
          end else begin
            out      <= {sign_r, res15};
            overflow <= 1'b0;
            sub      <= (res15[14:10] == 5'h00);
            dz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
